rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter N_CH, default 3: number of reset channels, each released in order (>=1).
REQ-002 SHALL have parameter STRETCH, default 16: cycles all channels stay asserted after lock is seen (>=1).
REQ-003 SHALL have parameter STAGGER, default 4: cycles between successive channel releases (>=1).
REQ-004 SHALL have parameter SYNC_STAGES, default 2: flip-flop stages synchronising pll_locked (>=2).
REQ-005 SHALL have port wb_clk  input  1  single clock for all logic.
REQ-006 SHALL have port wb_rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port pll_locked  input  1  PLL lock, asynchronous to wb_clk.
REQ-008 SHALL have port sw_rst_req  input  1  software reset request, synchronous single-cycle pulse.
REQ-009 SHALL have port rst_out  output  N_CH  per-channel reset, active-high, bit 0 released first.
REQ-010 SHALL have port ready  output  1  high when all channels are released.
REQ-011 SHALL have port cause  output  2  last reset cause: 01 external, 10 lock loss, 11 software, 00 unused.

Function
REQ-012 SHALL pass pll_locked through SYNC_STAGES flops; lock_s denotes the synchroniser output.
REQ-013 SHALL implement states WAIT_LOCK, STRETCH, RELEASE, RUN.
REQ-014 WAIT_LOCK: all rst_out high, ready low; on lock_s high -> STRETCH with counter cleared.
REQ-015 STRETCH: counter increments each cycle; on count STRETCH-1 -> RELEASE, rst_out[0] falls on that same edge, channel index = 1, counter cleared.
REQ-016 RELEASE: every STAGGER cycles release channel at index, then increment index; releasing channel N_CH-1 -> RUN with ready rising on the same edge.
REQ-017 N_CH=1: STRETCH -> RUN directly; rst_out[0] falls and ready rises on the same edge.
REQ-018 Released channels SHALL stay low until a re-assert event; rst_out is monotonic within one sequence.
REQ-019 Lock loss (lock_s low) in STRETCH, RELEASE or RUN: all rst_out high and ready low on the next edge, cause=10, -> WAIT_LOCK.
REQ-020 sw_rst_req in RUN: all rst_out high and ready low on the next edge, cause=11, -> STRETCH (no lock wait).
REQ-021 sw_rst_req outside RUN SHALL be ignored.
REQ-022 Lock loss and sw_rst_req in the same cycle: lock loss wins, cause=10.
REQ-023 Counter width SHALL be $clog2(max(STRETCH,STAGGER))+1 bits; index width $clog2(N_CH)+1 bits; no wrap permitted.

Reset
REQ-024 wb_rst high SHALL immediately (asynchronously) force rst_out all ones, ready 0, cause 01, state WAIT_LOCK, counter/index 0, synchroniser flops 0.
REQ-025 Assertion of wb_rst mid-sequence or in RUN SHALL abort and restart from WAIT_LOCK after deassertion.
REQ-026 All outputs SHALL be driven from flops; no combinational path from inputs to outputs.

Structure
REQ-027 State encoding and cause codes (CAUSE_EXT, CAUSE_LOCK, CAUSE_SW) SHALL live in shared package rst_pkg.
REQ-028 Synchroniser SHALL be sub-module sync_ff (parameter STAGES), reusable for other async inputs.
REQ-029 rst_seq SHALL be instantiated at SoC top level, replacing the fixed shift-register reset; rst_out[0] feeds wb_rst of the CPU subsystem.

Verification (N_CH=3, STRETCH=16, STAGGER=4, SYNC_STAGES=2)
REQ-030 pll_locked high, wb_rst released at cycle 0 -> lock_s high at cycle 2; rst_out 111->110 at cycle 18, ->100 at 22, ->000 and ready=1 at 26, cause=01.
REQ-031 pll_locked low for 50 cycles after reset, then high -> rst_out stays 111 until 18 cycles after lock rises, then sequence as REQ-030.
REQ-032 RUN, sw_rst_req 1-cycle pulse -> next edge rst_out=111, ready=0, cause=11; rst_out[0] falls 16 cycles later, ready after 8 more.
REQ-033 pll_locked drops during RELEASE (rst_out=110) -> rst_out=111 within SYNC_STAGES+1 cycles, cause=10, restart waits for relock.
REQ-034 Same-cycle lock_s low and sw_rst_req in RUN -> cause=10, state WAIT_LOCK; sw_rst_req during STRETCH -> no effect on timing.
REQ-035 wb_rst pulsed between clock edges in RUN -> rst_out=111, ready=0, cause=01 before the next edge.

Source files
------------

// File: rtl/rst_pkg.sv
// -----------------------------------------------------------------------------
// rst_pkg
// Shared definitions for the reset sequencer: FSM state encoding, reset-cause
// codes and a small elaboration-time helper used to size counters.
// -----------------------------------------------------------------------------
package rst_pkg;

    // Sequencer states.
    //   ST_WAIT_LOCK : everything held in reset until the PLL reports lock
    //   ST_STRETCH   : lock seen, all channels held for a fixed stretch time
    //   ST_RELEASE   : channels released one by one, staggered in time
    //   ST_RUN       : all channels out of reset
    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_STRETCH   = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } rst_state_t;

    // Last reset cause, as reported on the cause output.
    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_EXT  = 2'b01;  // external wb_rst
    localparam cause_t CAUSE_LOCK = 2'b10;  // PLL lock lost
    localparam cause_t CAUSE_SW   = 2'b11;  // software request

    // Larger of two integers; used to size the shared stretch/stagger counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : rst_pkg

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Multi-stage flip-flop synchroniser for a single asynchronous input.
// Reusable for any slow, level-type asynchronous signal.
//
// Parameters
//   STAGES : number of flip-flop stages (>= 2)
//
// Ports
//   clk : destination clock
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : asynchronous input
//   q   : synchronised output (last stage)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    // Plain shift chain: bit 0 samples the asynchronous input, each later
    // stage gives the previous one a full cycle to resolve metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= '0;
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d};
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule : sync_ff

// File: rtl/rst_seq.sv
// -----------------------------------------------------------------------------
// rst_seq
// Power-on / lock-driven reset sequencer. Holds N_CH reset channels asserted
// until the PLL is locked, stretches the reset for STRETCH cycles, then
// releases the channels in order (bit 0 first) STAGGER cycles apart. Lock
// loss, a software request or the external reset re-assert all channels and
// the last cause is reported on cause. rst_out[0] is meant to drive the reset
// of the CPU subsystem, so the CPU leaves reset first.
//
// Parameters
//   N_CH        : number of reset channels (>= 1)
//   STRETCH     : cycles all channels stay asserted after lock is seen (>= 1)
//   STAGGER     : cycles between successive channel releases (>= 1)
//   SYNC_STAGES : synchroniser depth for pll_locked (>= 2)
//
// Ports
//   wb_clk     : single clock for all logic
//   wb_rst     : asynchronous active-high reset
//   pll_locked : PLL lock indication, asynchronous to wb_clk
//   sw_rst_req : software reset request, single-cycle pulse on wb_clk
//   rst_out    : per-channel active-high reset, bit 0 released first
//   ready      : high when every channel is released
//   cause      : last reset cause (01 external, 10 lock loss, 11 software)
// -----------------------------------------------------------------------------
module rst_seq
    import rst_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int STRETCH     = 16,
    parameter int STAGGER     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic            pll_locked,
    input  logic            sw_rst_req,
    output logic [N_CH-1:0] rst_out,
    output logic            ready,
    output logic [1:0]      cause
);

    // One counter serves both the stretch and the stagger phases, so it is
    // sized for the longer of the two. The extra bit keeps terminal values
    // representable without wrap.
    localparam int CW = $clog2(max_int(STRETCH, STAGGER)) + 1;
    localparam int IW = $clog2(N_CH) + 1;

    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
    localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(N_CH - 1);
    // Channel 0 is released on leaving STRETCH, so RELEASE starts at 1.
    localparam logic [IW-1:0] IDX_SECOND   = IW'(1);

    // -------------------------------------------------------------------------
    // Lock synchroniser
    // -------------------------------------------------------------------------
    logic lock_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (wb_clk),
        .rst (wb_rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // -------------------------------------------------------------------------
    // Sequencer state
    // -------------------------------------------------------------------------
    rst_state_t      state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [IW-1:0]   idx_reg;
    logic [N_CH-1:0] rst_out_reg;
    logic            ready_reg;
    cause_t          cause_reg;

    // One-hot select of the channel addressed by idx_reg; used to clear
    // exactly that channel when its stagger slot expires.
    logic [N_CH-1:0] release_sel;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_release_sel
            assign release_sel[gi] = (idx_reg == IW'(gi));
        end
    endgenerate

    logic stretch_done;
    logic stagger_done;
    logic last_channel;
    logic lock_lost;
    logic sw_abort;

    assign stretch_done = (cnt_reg == STRETCH_LAST);
    assign stagger_done = (cnt_reg == STAGGER_LAST);
    assign last_channel = (idx_reg == IDX_LAST);

    // Lock loss only matters once we have left WAIT_LOCK; it takes priority
    // over a software request arriving in the same cycle.
    assign lock_lost = (state_reg != ST_WAIT_LOCK) && !lock_s;
    assign sw_abort  = (state_reg == ST_RUN) && sw_rst_req;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_reg   <= ST_WAIT_LOCK;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            rst_out_reg <= '1;
            ready_reg   <= 1'b0;
            cause_reg   <= CAUSE_EXT;
        end else if (lock_lost) begin
            state_reg   <= ST_WAIT_LOCK;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            rst_out_reg <= '1;
            ready_reg   <= 1'b0;
            cause_reg   <= CAUSE_LOCK;
        end else if (sw_abort) begin
            // PLL is still locked, so skip WAIT_LOCK and restart the stretch.
            state_reg   <= ST_STRETCH;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            rst_out_reg <= '1;
            ready_reg   <= 1'b0;
            cause_reg   <= CAUSE_SW;
        end else begin
            unique case (state_reg)
                ST_WAIT_LOCK: begin
                    rst_out_reg <= '1;
                    ready_reg   <= 1'b0;
                    cnt_reg     <= '0;
                    idx_reg     <= '0;
                    if (lock_s) begin
                        state_reg <= ST_STRETCH;
                    end
                end

                ST_STRETCH: begin
                    if (stretch_done) begin
                        // Channel 0 leaves reset on the same edge we leave
                        // STRETCH; with a single channel we are done.
                        rst_out_reg[0] <= 1'b0;
                        cnt_reg        <= '0;
                        if (N_CH == 1) begin
                            state_reg <= ST_RUN;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_RELEASE;
                            idx_reg   <= IDX_SECOND;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (stagger_done) begin
                        // Clearing bits only (AND with inverted select) keeps
                        // rst_out monotonic within a sequence.
                        rst_out_reg <= rst_out_reg & ~release_sel;
                        cnt_reg     <= '0;
                        if (last_channel) begin
                            state_reg <= ST_RUN;
                            ready_reg <= 1'b1;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                ST_RUN: begin
                    // Hold; exits are handled by the abort branches above.
                    rst_out_reg <= '0;
                    ready_reg   <= 1'b1;
                end

                default: begin
                    state_reg   <= ST_WAIT_LOCK;
                    rst_out_reg <= '1;
                    ready_reg   <= 1'b0;
                end
            endcase
        end
    end

    // All outputs come straight from flops.
    assign rst_out = rst_out_reg;
    assign ready   = ready_reg;
    assign cause   = cause_reg;

endmodule : rst_seq

// File: tb/tb_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_rst_seq
// Directed testbench for rst_seq with N_CH=3, STRETCH=16, STAGGER=4,
// SYNC_STAGES=2. Edge 0 is the first rising edge after wb_rst is released.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_rst_seq;

    localparam int N_CH        = 3;
    localparam int STRETCH     = 16;
    localparam int STAGGER     = 4;
    localparam int SYNC_STAGES = 2;

    logic            wb_clk     = 1'b0;
    logic            wb_rst     = 1'b0;
    logic            pll_locked = 1'b0;
    logic            sw_rst_req = 1'b0;
    logic [N_CH-1:0] rst_out;
    logic            ready;
    logic [1:0]      cause;

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_n       = 0;
    int base;

    rst_seq #(
        .N_CH        (N_CH),
        .STRETCH     (STRETCH),
        .STAGGER     (STAGGER),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .pll_locked (pll_locked),
        .sw_rst_req (sw_rst_req),
        .rst_out    (rst_out),
        .ready      (ready),
        .cause      (cause)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] r,
                              input logic rd, input logic [1:0] c);
        $display("[TB] edge %0d %s: rst_out=%b ready=%b cause=%b", edge_n, tag, rst_out, ready, cause);
        chk({tag, "/rst_out"}, {5'b0, rst_out}, {5'b0, r});
        chk({tag, "/ready"},   {7'b0, ready},   {7'b0, rd});
        chk({tag, "/cause"},   {6'b0, cause},   {6'b0, c});
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
        edge_n++;
    endtask

    task automatic goto(input int e);
        while (edge_n < e) tick();
    endtask

    initial begin
        // ---------------- external reset, lock already present --------------
        #1 wb_rst = 1'b1;
        pll_locked = 1'b1;
        #1 expect_out("reset_async", 3'b111, 1'b0, 2'b01);
        tick();
        tick();
        expect_out("reset_held", 3'b111, 1'b0, 2'b01);
        wb_rst = 1'b0;
        edge_n = -1;

        // ---------------- power-up sequence -------------------------------
        goto(17); expect_out("pwr_stretch_end", 3'b111, 1'b0, 2'b01);
        goto(18); expect_out("pwr_ch0",         3'b110, 1'b0, 2'b01);
        goto(21); expect_out("pwr_ch0_hold",    3'b110, 1'b0, 2'b01);
        goto(22); expect_out("pwr_ch1",         3'b100, 1'b0, 2'b01);
        goto(25); expect_out("pwr_ch1_hold",    3'b100, 1'b0, 2'b01);
        goto(26); expect_out("pwr_run",         3'b000, 1'b1, 2'b01);
        goto(30); expect_out("pwr_run_hold",    3'b000, 1'b1, 2'b01);

        // ---------------- software reset in RUN ----------------------------
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        base = edge_n;
        expect_out("sw_assert", 3'b111, 1'b0, 2'b11);
        // a request during STRETCH must not disturb the timing
        goto(base + 5);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        goto(base + 15); expect_out("sw_stretch_end", 3'b111, 1'b0, 2'b11);
        goto(base + 16); expect_out("sw_ch0",         3'b110, 1'b0, 2'b11);
        goto(base + 20); expect_out("sw_ch1",         3'b100, 1'b0, 2'b11);
        goto(base + 23); expect_out("sw_ch1_hold",    3'b100, 1'b0, 2'b11);
        goto(base + 24); expect_out("sw_run",         3'b000, 1'b1, 2'b11);

        // ---------------- lock loss during RELEASE -------------------------
        goto(base + 28);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        base = edge_n;
        expect_out("ll_sw_assert", 3'b111, 1'b0, 2'b11);
        goto(base + 16); expect_out("ll_release", 3'b110, 1'b0, 2'b11);
        pll_locked = 1'b0;
        goto(base + 18); expect_out("ll_sync_delay", 3'b110, 1'b0, 2'b11);
        goto(base + 19); expect_out("ll_assert",     3'b111, 1'b0, 2'b10);
        goto(base + 30); expect_out("ll_wait_lock",  3'b111, 1'b0, 2'b10);
        pll_locked = 1'b1;
        base = edge_n;
        goto(base + 18); expect_out("relock_stretch", 3'b111, 1'b0, 2'b10);
        goto(base + 19); expect_out("relock_ch0",     3'b110, 1'b0, 2'b10);
        goto(base + 23); expect_out("relock_ch1",     3'b100, 1'b0, 2'b10);
        goto(base + 27); expect_out("relock_run",     3'b000, 1'b1, 2'b10);

        // ---------------- lock loss and sw request together ----------------
        goto(base + 30);
        base = edge_n;
        pll_locked = 1'b0;
        goto(base + 2); expect_out("both_pre", 3'b000, 1'b1, 2'b10);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        pll_locked = 1'b1;
        expect_out("both_lock_wins", 3'b111, 1'b0, 2'b10);
        // back through WAIT_LOCK: lock_s high after base+5, STRETCH from base+6
        goto(base + 21); expect_out("both_stretch_end", 3'b111, 1'b0, 2'b10);
        goto(base + 22); expect_out("both_ch0",         3'b110, 1'b0, 2'b10);
        goto(base + 30); expect_out("both_run",         3'b000, 1'b1, 2'b10);

        // ---------------- async wb_rst pulse in RUN, then late lock --------
        goto(base + 35);
        #2 wb_rst = 1'b1;
        #1 expect_out("async_rst_pulse", 3'b111, 1'b0, 2'b01);
        pll_locked = 1'b0;
        #2 wb_rst = 1'b0;
        edge_n = -1;
        goto(49); expect_out("late_lock_wait",  3'b111, 1'b0, 2'b01);
        pll_locked = 1'b1;
        goto(67); expect_out("late_lock_hold",  3'b111, 1'b0, 2'b01);
        goto(68); expect_out("late_lock_ch0",   3'b110, 1'b0, 2'b01);
        goto(72); expect_out("late_lock_ch1",   3'b100, 1'b0, 2'b01);
        goto(76); expect_out("late_lock_run",   3'b000, 1'b1, 2'b01);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_rst_seq
